data_sram_responder: RTL and testbench

- Memory-side responder for the CPU data-SRAM port: it is the slave that produces the read data the memory stage consumes.
- It accepts requests from the execute stage over a req/addr_ok handshake and returns completions in order over a data_ok/rdata pulse, after a fixed, programmable latency.
- It holds a word-addressed storage array with byte write strobes.
- It replaces the zero-wait SRAM model, so the pipeline can be exercised with multi-cycle, pipelined memory.

---
 rtl/data_sram_responder_if.sv | 22 ++
 rtl/data_sram_responder.sv | 109 ++++++++++
 tb/tb_data_sram_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM port: request handshake from execute, in-order completions to memory stage.
`timescale 1ns/1ps
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM slave: word array with byte strobes, fixed-latency in-order completions
// through a small circular queue of accepted requests.
`timescale 1ns/1ps
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW    = $clog2(OUTSTANDING + 1);
  localparam int unsigned DW    = 3;

  typedef struct packed {
    logic          is_write;
    logic [31:0]   data;
    logic [DW-1:0] countdown;
  } entry_t;

  entry_t                q   [OUTSTANDING];
  entry_t                q_n [OUTSTANDING];
  logic [PW-1:0]         head, head_n, tail, tail_n;
  logic [CW-1:0]         count, count_n;
  logic                  data_ok_q, data_ok_n;
  logic [31:0]           rdata_q, rdata_n;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  push, pop;
  logic                  unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx              = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.data_sram_addr[31:DEPTH_LOG2+2], bus.data_sram_addr[1:0]};

  // No pop-bypass: a full queue refuses even while its head retires.
  assign bus.data_sram_addr_ok = bus.data_sram_req && (count < CW'(OUTSTANDING));
  assign push                  = bus.data_sram_req && bus.data_sram_addr_ok;
  assign pop                   = data_ok_q;

  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

  // Next queue state; data_ok/rdata are precomputed from it so they leave a flop.
  always_comb begin
    q_n     = q;
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    for (int i = 0; i < int'(OUTSTANDING); i++) begin
      q_n[i].countdown = (q[i].countdown != '0) ? q[i].countdown - DW'(1) : '0;
    end
    if (push) begin
      q_n[tail].is_write  = bus.data_sram_wr;
      q_n[tail].data      = bus.data_sram_wr ? 32'h0 : mem[idx];
      q_n[tail].countdown = DW'(LATENCY - 1);
      tail_n              = next_ptr(tail);
    end
    if (pop) begin
      head_n = next_ptr(head);
    end
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    data_ok_n = (count_n != '0) && (q_n[head_n].countdown == '0);
    rdata_n   = (data_ok_n && !q_n[head_n].is_write) ? q_n[head_n].data : 32'h0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        q[i] <= '0;
      end
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      data_ok_q <= data_ok_n;
      rdata_q   <= rdata_n;
      q         <= q_n;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) begin
          mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: LATENCY=2 and LATENCY=4 instances,
// directed vectors, monitor checks every completion for data and exact cycle.
`timescale 1ns/1ps
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   vectors = 0;
  int   errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder_if bus0();
  data_sram_responder_if bus1();

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .OUTSTANDING(2)) u0 (
    .clk(clk), .resetn(resetn), .bus(bus0)
  );
  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(4), .OUTSTANDING(2)) u1 (
    .clk(clk), .resetn(resetn), .bus(bus1)
  );

  typedef struct { logic [31:0] data; int due; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

  exp_t sb0[$];
  exp_t sb1[$];
  chk_t side_q[$];

  function automatic void side(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n; c.act = a; c.exp = e;
    side_q.push_back(c);
  endfunction

  function automatic logic aok(input int sel);
    return (sel == 0) ? bus0.data_sram_addr_ok : bus1.data_sram_addr_ok;
  endfunction

  task automatic drive(input int sel, input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (sel == 0) begin
      bus0.data_sram_req = req; bus0.data_sram_wr = wr; bus0.data_sram_addr = addr;
      bus0.data_sram_wdata = wdata; bus0.data_sram_wstrb = wstrb;
    end else begin
      bus1.data_sram_req = req; bus1.data_sram_wr = wr; bus1.data_sram_addr = addr;
      bus1.data_sram_wdata = wdata; bus1.data_sram_wstrb = wstrb;
    end
  endtask

  // Present one request until accepted; expected completion is queued at acceptance.
  task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] exp);
    int   lat;
    bit   ok;
    exp_t e;
    lat = (sel == 0) ? 2 : 4;
    ok  = 1'b0;
    drive(sel, 1'b1, wr, addr, wdata, wstrb);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (aok(sel)) begin
        ok = 1'b1;
        e.data = exp; e.due = cyc + lat;
        if (sel == 0) sb0.push_back(e); else sb1.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!ok) side("accept_timeout", 32'h0, 32'h1);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mon(input int k, input logic ok, input logic [31:0] rd);
    exp_t e;
    int   sz;
    sz = (k == 0) ? sb0.size() : sb1.size();
    if (ok) begin
      vectors++;
      if (sz == 0) begin
        errs++;
        $display("FAIL spurious_data_ok[%0d]: got data_ok=1 rdata=%h at cycle %0d, want no completion", k, rd, cyc);
      end else begin
        if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        if (rd !== e.data || cyc != e.due) begin
          errs++;
          $display("FAIL completion[%0d]: got rdata=%h at cycle %0d, want rdata=%h at cycle %0d",
                   k, rd, cyc, e.data, e.due);
        end
      end
    end else begin
      if (rd !== 32'h0) begin
        vectors++; errs++;
        $display("FAIL idle_rdata[%0d]: got %h, want 00000000", k, rd);
      end
      if (sz > 0) begin
        e = (k == 0) ? sb0[0] : sb1[0];
        if (cyc > e.due) begin
          vectors++; errs++;
          $display("FAIL missing_data_ok[%0d]: got none by cycle %0d, want rdata=%h at cycle %0d",
                   k, cyc, e.data, e.due);
          if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        end
      end
    end
  endtask

  // Single checking process: completions of both instances plus queued point checks.
  always @(negedge clk) begin
    chk_t c;
    mon(0, bus0.data_sram_data_ok, bus0.data_sram_rdata);
    mon(1, bus1.data_sram_data_ok, bus1.data_sram_rdata);
    while (side_q.size() > 0) begin
      c = side_q.pop_front();
      vectors++;
      if (c.act !== c.exp) begin
        errs++;
        $display("FAIL %s: got %h, want %h", c.name, c.act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

  bit   bp_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int   k;
  exp_t e;

  initial begin
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset then idle
    repeat (3) begin
      @(negedge clk);
      side("rst_addr_ok", 32'(bus0.data_sram_addr_ok), 32'h0);
      side("rst_data_ok", 32'(bus0.data_sram_data_ok), 32'h0);
      side("rst_rdata",   bus0.data_sram_rdata,        32'h0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(4);

    // Write then back-to-back read
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF);

    // Byte strobes and ignored addr[1:0]
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
    issue(0, 1'b0, 32'h22, 32'h0, 4'h0, 32'h11BB33DD);

    // Zero strobe still completes and leaves the word alone
    issue(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

    // Aliasing modulo 1024 words
    issue(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h0,    32'h0,        4'h0, 32'h5A5A5A5A);

    // Long streams for pointer wrap
    for (int i = 0; i < 10; i++)
      issue(0, 1'b1, 32'h100 + 32'(4*i), 32'h01010101 * 32'(i + 1), 4'hF, 32'h0);
    for (int i = 0; i < 10; i++)
      issue(0, 1'b0, 32'h100 + 32'(4*i), 32'h0, 4'h0, 32'h01010101 * 32'(i + 1));
    idle(4);

    // Backpressure on LATENCY=4, OUTSTANDING=2
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0);
    idle(8);
    k = 0;
    drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      side("bp_addr_ok", 32'(bus1.data_sram_addr_ok), 32'(bp_pat[c]));
      if (bus1.data_sram_addr_ok) begin
        e.data = 32'hC0DE0000 + 32'(k); e.due = cyc + 4;
        sb1.push_back(e);
        k++;
      end
      @(posedge clk); #1;
      bus1.data_sram_addr = 32'h40 + 32'(4*k);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    side("bp_accept_count", 32'(k), 32'd4);
    idle(8);

    // Reset mid-flight: both reads must vanish
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
    resetn = 1'b0;
    sb0.delete();
    idle(2);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    resetn = 1'b1;
    @(negedge clk);
    side("post_reset_addr_ok", 32'(bus0.data_sram_addr_ok), 32'h1);
    if (bus0.data_sram_addr_ok) begin
      e.data = 32'h5A5A5A5A; e.due = cyc + 2;
      sb0.push_back(e);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Drain with a bound
    for (int t = 0; t < 100 && (sb0.size() > 0 || sb1.size() > 0); t++) idle(1);
    side("drain_pending", 32'(sb0.size() + sb1.size()), 32'h0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
